multdiv_ctrl: RTL and testbench

- Sequences the shared multiply/divide unit from the EX stage and owns the EX-stage stall for those instructions.
- Latches each request and holds funct and operands stable until the unit reports done. Commits the result to HI/LO, or to the GPR for MUL, and enforces the unit's restart contract.
- Unit contract: done may stay high while funct is unchanged. A restart therefore needs at least one cycle of funct = 0, and an aborted op needs a drain period.

---
 rtl/multdiv_ctrl_pkg.sv | 27 ++
 rtl/multdiv_ctrl.sv | 132 +++++++++++++
 tb/tb_multdiv_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_ctrl_pkg.sv
// Shared funct codes, state encoding and decode helpers for the mult/div controller.
// SPECIAL2 ops carry bit 5 set so that no real operation ever encodes as the idle code 0.
package multdiv_ctrl_pkg;

    localparam logic [5:0] FUNCT_IDLE   = 6'h00;
    localparam logic [5:0] FUNCT_MULT   = 6'h18;
    localparam logic [5:0] FUNCT_MULTU  = 6'h19;
    localparam logic [5:0] FUNCT_DIV    = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU   = 6'h1B;
    localparam logic [5:0] FUNCT2_MADD  = 6'h20;
    localparam logic [5:0] FUNCT2_MADDU = 6'h21;
    localparam logic [5:0] FUNCT2_MUL   = 6'h22;
    localparam logic [5:0] FUNCT2_MSUB  = 6'h24;
    localparam logic [5:0] FUNCT2_MSUBU = 6'h25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic is_mul_to_gpr(input logic [5:0] f);
        return f == FUNCT2_MUL;
    endfunction

endpackage

// File: rtl/multdiv_ctrl.sv
// EX-stage sequencer for the shared multiply/divide unit: latches the request, owns the
// EX stall, commits the result to HI/LO or the GPR, and enforces the unit restart contract.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int FUNCT_W    = 6,
    parameter int DIV_CYCLES = 17,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic [DATA_W-1:0]     op1,
    input  logic [DATA_W-1:0]     op2,
    input  logic [DATA_W-1:0]     hi_in,
    input  logic [DATA_W-1:0]     lo_in,
    input  logic                  flush,
    input  logic                  stall_in,
    output logic [FUNCT_W-1:0]    md_funct,
    output logic [DATA_W-1:0]     md_op1,
    output logic [DATA_W-1:0]     md_op2,
    output logic [DATA_W-1:0]     md_hi,
    output logic [DATA_W-1:0]     md_lo,
    input  logic                  md_done,
    input  logic [2*DATA_W-1:0]   md_result,
    output logic                  stall_req,
    output logic                  hilo_we,
    output logic [DATA_W-1:0]     hi_wdata,
    output logic [DATA_W-1:0]     lo_wdata,
    output logic                  gpr_we,
    output logic [DATA_W-1:0]     gpr_wdata,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    state_t                r_state, w_next;
    logic [FUNCT_W-1:0]    r_funct;
    logic [DATA_W-1:0]     r_op1, r_op2, r_hi, r_lo;
    logic [2*DATA_W-1:0]   r_res;
    logic [CNT_W-1:0]      r_cnt;

    logic w_latch, w_capture, w_load, w_strobe, w_is_mul;

    assign w_is_mul = is_mul_to_gpr(6'(r_funct));

    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        w_load    = 1'b0;
        w_strobe  = 1'b0;
        stall_req = 1'b0;
        md_funct  = '0;
        case (r_state)
            ST_IDLE: begin
                stall_req = req & ~flush;
                if (req && !flush) begin
                    w_latch = 1'b1;
                    w_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                stall_req = 1'b1;
                md_funct  = r_funct;
                // A flush wins over done: the unit may still be mid-op, so drain it.
                if (flush) begin
                    w_load = 1'b1;
                    w_next = ST_DRAIN;
                end else if (md_done) begin
                    w_capture = 1'b1;
                    w_next    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    w_next = ST_IDLE;
                end else if (!stall_in) begin
                    w_strobe = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                stall_req = req;
                if (r_cnt <= CNT_W'(1))
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_funct <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_funct <= funct;
                r_op1   <= op1;
                r_op2   <= op2;
                r_hi    <= hi_in;
                r_lo    <= lo_in;
            end
            if (w_capture)
                r_res <= md_result;
            if (w_load)
                r_cnt <= CNT_W'(DIV_CYCLES);
            else if (r_state == ST_DRAIN && r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign md_op1    = r_op1;
    assign md_op2    = r_op2;
    assign md_hi     = r_hi;
    assign md_lo     = r_lo;
    assign hilo_we   = w_strobe & ~w_is_mul;
    assign gpr_we    = w_strobe & w_is_mul;
    assign hi_wdata  = r_res[2*DATA_W-1:DATA_W];
    assign lo_wdata  = r_res[DATA_W-1:0];
    assign gpr_wdata = r_res[DATA_W-1:0];
    assign busy      = r_state != ST_IDLE;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl driving a behavioural mult/div unit with the
// done-held-while-funct-stable contract (mult latency 5, div latency 17).
module tb_multdiv_ctrl;
    import multdiv_ctrl_pkg::*;

    localparam int FW = 6;
    localparam int DW = 32;
    localparam int DC = 17;

    logic          clk = 1'b0;
    logic          rst, req, flush, stall_in;
    logic [FW-1:0] funct;
    logic [DW-1:0] op1, op2, hi_in, lo_in;
    logic [FW-1:0] md_funct;
    logic [DW-1:0] md_op1, md_op2, md_hi, md_lo;
    logic          md_done;
    logic [2*DW-1:0] md_result;
    logic          stall_req, hilo_we, gpr_we, busy;
    logic [DW-1:0] hi_wdata, lo_wdata, gpr_wdata;

    int errors = 0;
    int checks = 0;
    int n_hilo = 0;
    int n_gpr  = 0;

    always #5 clk = ~clk;

    multdiv_ctrl #(.FUNCT_W(FW), .DIV_CYCLES(DC), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .funct(funct), .op1(op1), .op2(op2),
        .hi_in(hi_in), .lo_in(lo_in), .flush(flush), .stall_in(stall_in),
        .md_funct(md_funct), .md_op1(md_op1), .md_op2(md_op2), .md_hi(md_hi), .md_lo(md_lo),
        .md_done(md_done), .md_result(md_result), .stall_req(stall_req),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .gpr_we(gpr_we), .gpr_wdata(gpr_wdata), .busy(busy)
    );

    // ---------------- behavioural unit ----------------
    function automatic logic [63:0] unit_calc(input logic [5:0] f, input logic [31:0] a, b, h, l);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] q, r;
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up = {32'b0, a} * {32'b0, b};
        case (f)
            FUNCT_MULT:   return sp;
            FUNCT_MULTU:  return up;
            FUNCT2_MUL:   return sp;
            FUNCT_DIV: begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            FUNCT_DIVU:   return {a % b, a / b};
            FUNCT2_MADD:  return {h, l} + sp;
            FUNCT2_MADDU: return {h, l} + up;
            FUNCT2_MSUB:  return {h, l} - sp;
            FUNCT2_MSUBU: return {h, l} - up;
            default:      return 64'h0;
        endcase
    endfunction

    int u_cnt;
    int u_lat;
    assign u_lat = (md_funct == FUNCT_DIV || md_funct == FUNCT_DIVU) ? 17 : 5;

    always @(posedge clk) begin
        if (rst || md_funct == FUNCT_IDLE) begin
            u_cnt     <= 0;
            md_done   <= 1'b0;
            md_result <= '0;
        end else if (!md_done) begin
            u_cnt <= u_cnt + 1;
            if (u_cnt == u_lat - 1) begin
                md_done   <= 1'b1;
                md_result <= unit_calc(md_funct, md_op1, md_op2, md_hi, md_lo);
            end
        end
    end

    always @(posedge clk) begin
        if (hilo_we) n_hilo <= n_hilo + 1;
        if (gpr_we)  n_gpr  <= n_gpr + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] f, input logic [31:0] a, b, h, l);
        req = 1'b1; funct = f; op1 = a; op2 = b; hi_in = h; lo_in = l;
    endtask

    // Waits (bounded) for a write strobe; reports cycles before it, stalled cycles,
    // and md_funct==0 cycles before the unit first sees a nonzero funct.
    task automatic wait_strobe(input string tag, output int cyc, output int nstall, output int nzero,
                               output logic hwe, output logic gwe,
                               output logic [31:0] hw, output logic [31:0] lw, output logic [31:0] gw);
        bit seen_run;
        cyc = 0; nstall = 0; nzero = 0; seen_run = 0;
        hwe = 0; gwe = 0; hw = '0; lw = '0; gw = '0;
        while (cyc < 100) begin
            @(negedge clk);
            if (hilo_we || gpr_we) begin
                hwe = hilo_we; gwe = gpr_we; hw = hi_wdata; lw = lo_wdata; gw = gpr_wdata;
                break;
            end
            if (stall_req) nstall++;
            if (!seen_run) begin
                if (md_funct == FUNCT_IDLE) nzero++;
                else seen_run = 1;
            end
            cyc++;
        end
        chk({tag, "_strobe_seen"}, 64'(hwe | gwe), 64'd1);
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    int cyc, nst, nz, h0, g0, n;
    logic hwe, gwe;
    logic [31:0] hw, lw, gw;

    initial begin
        rst = 1'b1; req = 1'b0; flush = 1'b0; stall_in = 1'b0;
        funct = '0; op1 = '0; op2 = '0; hi_in = '0; lo_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_funct", 64'(md_funct), 64'd0);
        chk("rst_we", 64'({hilo_we, gpr_we}), 64'd0);
        chk("rst_data", {hi_wdata, lo_wdata}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // MULT 3 * -4
        @(posedge clk); #1;
        h0 = n_hilo; g0 = n_gpr;
        set_in(FUNCT_MULT, 32'd3, 32'hFFFFFFFC, 32'd0, 32'd0);
        wait_strobe("mult", cyc, nst, nz, hwe, gwe, hw, lw, gw);
        chk("mult_stall_until_hold", 64'(nst), 64'(cyc));
        chk("mult_stall_low_in_hold", 64'(stall_req), 64'd0);
        chk("mult_hilo_we", 64'({hwe, gwe}), 64'b10);
        chk("mult_result", {hw, lw}, 64'hFFFFFFFF_FFFFFFF4);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("mult_one_pulse", 64'(hilo_we), 64'd0);
        chk("mult_back_idle", 64'(busy), 64'd0);
        chk("mult_pulse_count", 64'({n_hilo - h0, n_gpr - g0}), {32'd1, 32'd0});

        // DIV 7 / -2
        @(posedge clk); #1;
        set_in(FUNCT_DIV, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0);
        wait_strobe("div", cyc, nst, nz, hwe, gwe, hw, lw, gw);
        chk("div_stall_ge17", 64'(nst >= 17), 64'd1);
        chk("div_hilo_we", 64'({hwe, gwe}), 64'b10);
        chk("div_result", {hw, lw}, 64'h00000001_FFFFFFFD);
        @(posedge clk); #1 req = 1'b0;

        // MADD with HOLD back-pressure for 3 cycles
        @(posedge clk); #1;
        h0 = n_hilo;
        set_in(FUNCT2_MADD, 32'd2, 32'd3, 32'd0, 32'd5);
        stall_in = 1'b1;
        n = 0;
        while (!(busy && !stall_req) && n < 100) begin @(negedge clk); n++; end
        chk("madd_hold_reached", 64'(busy && !stall_req), 64'd1);
        chk("madd_held_c1", 64'(hilo_we), 64'd0);
        @(negedge clk);
        chk("madd_held_c2", 64'(hilo_we), 64'd0);
        @(negedge clk);
        chk("madd_held_c3", 64'(hilo_we), 64'd0);
        chk("madd_data_held", {hi_wdata, lo_wdata}, 64'd11);
        @(posedge clk); #1 stall_in = 1'b0;
        @(negedge clk);
        chk("madd_hilo_we", 64'(hilo_we), 64'd1);
        chk("madd_result", {hi_wdata, lo_wdata}, 64'd11);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("madd_pulse_count", 64'(n_hilo - h0), 64'd1);

        // MUL 6*7 twice, back to back
        @(posedge clk); #1;
        h0 = n_hilo; g0 = n_gpr;
        set_in(FUNCT2_MUL, 32'd6, 32'd7, 32'd0, 32'd0);
        wait_strobe("mul1", cyc, nst, nz, hwe, gwe, hw, lw, gw);
        chk("mul1_gpr_we", 64'({hwe, gwe}), 64'b01);
        chk("mul1_data", 64'(gw), 64'd42);
        wait_strobe("mul2", cyc, nst, nz, hwe, gwe, hw, lw, gw);
        chk("mul2_funct_gap", 64'(nz >= 1), 64'd1);
        chk("mul2_gpr_we", 64'({hwe, gwe}), 64'b01);
        chk("mul2_data", 64'(gw), 64'd42);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("mul_pulse_count", 64'({n_hilo - h0, n_gpr - g0}), {32'd0, 32'd2});

        // DIVU flushed 3 cycles into RUN, then MULTU 5*5 waits out the drain
        @(posedge clk); #1;
        h0 = n_hilo; g0 = n_gpr;
        set_in(FUNCT_DIVU, 32'd100, 32'd7, 32'd0, 32'd0);
        wait_busy("divu");
        repeat (2) @(negedge clk);
        @(posedge clk); #1 flush = 1'b1; req = 1'b0;
        @(posedge clk); #1 flush = 1'b0;
        set_in(FUNCT_MULTU, 32'd5, 32'd5, 32'd0, 32'd0);
        @(negedge clk);
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_stall_follows_req", 64'(stall_req), 64'd1);
        chk("drain_funct_zero", 64'(md_funct), 64'd0);
        wait_strobe("multu", cyc, nst, nz, hwe, gwe, hw, lw, gw);
        chk("multu_after_drain", 64'((nz + 1) >= DC + 1), 64'd1);
        chk("multu_result", {hw, lw}, 64'd25);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("divu_no_strobe", 64'({n_hilo - h0, n_gpr - g0}), {32'd1, 32'd0});

        // reset in the middle of a DIV
        @(posedge clk); #1;
        set_in(FUNCT_DIV, 32'd7, 32'd2, 32'd0, 32'd0);
        wait_busy("rstdiv");
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1; req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_ctl", 64'({md_funct, stall_req, hilo_we, gpr_we}), 64'd0);
        chk("rstmid_ops", {md_op1, md_op2}, 64'd0);
        chk("rstmid_hilo", {md_hi, md_lo}, 64'd0);
        chk("rstmid_wdata", {hi_wdata, lo_wdata}, 64'd0);
        @(posedge clk); #1;
        set_in(FUNCT_MULT, 32'd2, 32'd2, 32'd0, 32'd0);
        wait_strobe("mult22", cyc, nst, nz, hwe, gwe, hw, lw, gw);
        chk("mult22_result", {hw, lw}, 64'd4);
        @(posedge clk); #1 req = 1'b0;

        // unknown funct completes with zero through HI/LO
        @(posedge clk); #1;
        set_in(6'h3F, 32'd9, 32'd9, 32'd0, 32'd0);
        wait_strobe("unk", cyc, nst, nz, hwe, gwe, hw, lw, gw);
        chk("unk_hilo_we", 64'({hwe, gwe}), 64'b10);
        chk("unk_result", {hw, lw}, 64'd0);
        @(posedge clk); #1 req = 1'b0;

        // request with flush in IDLE is ignored
        @(posedge clk); #1;
        set_in(FUNCT_MULT, 32'd1, 32'd1, 32'd0, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1 flush = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("idle_flush_stays", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
